// File: rtl/dis_src_fifo.sv
// Circular-buffer source FIFO feeding a downstream enable-register stage via en/data_out.
// Optional same-edge empty bypass is enabled by defining DIS_SRC_BYPASS_EN.
module dis_src_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     hold,
  output logic                     en,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             en_q, en_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             push, pop, bypass;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign count    = count_q;
  assign en       = en_q;
  assign data_out = dout_q;

  always_comb begin
    bypass = 1'b0;
`ifdef DIS_SRC_BYPASS_EN
    bypass = empty && in_valid && !hold;
`else
`endif
    pop  = !empty && !hold;
    // A bypassed word goes straight to the output, so it must not also be stored.
    push = in_valid && in_ready && !bypass;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    en_d   = pop || bypass;
    dout_d = dout_q;
    if (pop)         dout_d = mem_q[rd_ptr_q];
    else if (bypass) dout_d = in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      en_q     <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      en_q     <= en_d;
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: doc/dis_src_fifo.md
DIS_SRC_FIFO -- requirements
Module: dis_src_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the storage entries, which is a power of two and at least 2.
REQ-003 Port clk SHALL be an input, 1 bit, and the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit, and the asynchronous active-low reset (0 = in reset).
REQ-005 Port in_valid SHALL be an input, 1 bit, and the producer's data-valid signal.
REQ-006 Port in_ready SHALL be an output, 1 bit, and the block's space-available signal.
REQ-007 Port in_data SHALL be an input, WIDTH bits, and the producer's data word.
REQ-008 Port hold SHALL be an input, 1 bit, and the downstream stall; 1 = no word issued this cycle.
REQ-009 Port en SHALL be an output, 1 bit, and the one-cycle load strobe to the downstream enable-register stage.
REQ-010 Port data_out SHALL be an output, WIDTH bits, and the word qualified by en.
REQ-011 Port count SHALL be an output, clog2(DEPTH)+1 bits, and the number of stored entries.
REQ-012 Ports full and empty SHALL be outputs, 1 bit each, with full = (count==DEPTH) and empty = (count==0).

Function
REQ-013 in_ready SHALL equal !full combinationally; a push SHALL occur on an edge where in_valid && in_ready.
REQ-014 A pop SHALL occur on an edge where !empty && !hold, evaluated on pre-edge state.
REQ-015 On a pop, en SHALL be registered to 1 and data_out SHALL be registered to the head entry; otherwise en SHALL be registered to 0 and data_out SHALL hold its value.
REQ-016 Storage SHALL be a circular buffer with read and write pointers that wrap from DEPTH-1 to 0 without a gap.
REQ-017 Words SHALL issue in strict arrival order with no loss or duplication.
REQ-018 With push and pop on the same edge, count SHALL be unchanged and both pointers SHALL advance.
REQ-019 When full, in_valid SHALL be ignored; when a pop occurs on that edge, in_ready stays 0 for that cycle and the push SHALL NOT occur.
REQ-020 A push into an empty buffer SHALL NOT pop on the same edge unless DIS_SRC_BYPASS_EN is defined (REQ-026).
REQ-021 Latency (non-bypass) SHALL be: word accepted at edge k shows en=1 and data_out=word after edge k+1 at the earliest.
REQ-022 While hold=1, count SHALL NOT decrease, and en SHALL be 0 from the next edge.
REQ-023 count SHALL never exceed DEPTH and never underflow below 0.

Reset
REQ-024 While reset=0, the block SHALL immediately, without a clock, set en=0, data_out=0, count=0, both pointers=0, empty=1, full=0, and in_ready=1.
REQ-025 Reset asserted mid-operation SHALL discard all stored words; storage contents need not be cleared, and the first push after release SHALL be the first word issued.

Configuration
REQ-026 When macro DIS_SRC_BYPASS_EN is defined, a word presented while empty && in_valid && !hold SHALL be issued on the same edge (en=1 and data_out=in_data after edge k), without being stored, leaving count at 0.
REQ-027 When DIS_SRC_BYPASS_EN is undefined, no bypass path SHALL exist, and REQ-020 and REQ-021 SHALL govern.

Verification
REQ-028 Reset release, push 8'h55 at edge k, hold=0 -> en=1 and data_out=8'h55 after edge k+1 (after edge k with bypass), then en=0 and data_out holds 8'h55.
REQ-029 hold=1, push 8'hAA, 8'h55, 8'h33, 8'h99 -> count=4, full=1, in_ready=0; a fifth word 8'hF0 is not accepted; release hold -> en=1 for 4 consecutive cycles issuing AA, 55, 33, 99.
REQ-030 Continuous push and pop for 10 words 8'h00..8'h09 with hold=0 -> count stays at 1 or below (0 with bypass), output order is 00..09, and pointers wrap twice.
REQ-031 Push 2 words, then reset=0 asynchronously between edges -> en, data_out, and count become 0 before the next edge; after release no stale word issues.
REQ-032 Toggle hold every cycle with 4 stored words -> en=1 only on cycles following hold=0 edges, and data order is preserved.
REQ-033 Full buffer, with hold=0 and in_valid=1 on the same edge -> one pop, no push, count=3; the next edge accepts the word.
